// File: rtl/capsense_event_filter.sv
// capsense_event_filter: per-button debounce, toggle tracking and press /
// long-press / release event detection, queued in a small FIFO behind a
// valid/ready interface. All button state advances only on poll strobes.
module capsense_event_filter #(
  parameter int N          = 4,
  parameter int DEB_CNT    = 3,
  parameter int LONG_POLLS = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int IDXW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    sample_i,
  input  logic            sample_valid_i,
  output logic [N-1:0]    state_o,
  output logic [N-1:0]    toggle_o,
  output logic            evt_valid_o,
  input  logic            evt_ready_i,
  output logic [IDXW+1:0] evt_o,
  output logic            overflow_o
);

  localparam int EW = IDXW + 2;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = 4;
  localparam int LW = 8;

  localparam logic [CW-1:0] DEB_LIM   = CW'(DEB_CNT);
  localparam logic [LW-1:0] LONG_LIM  = LW'(LONG_POLLS);
  localparam logic [PW:0]   FIFO_FULL = (PW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] KIND_PRESS = 2'b01;
  localparam logic [1:0] KIND_LONG  = 2'b11;
  localparam logic [1:0] KIND_REL   = 2'b10;

  // Per-button state
  logic [CW-1:0] cnt_r    [N];
  logic [CW-1:0] cnt_nx_s [N];
  logic [LW-1:0] lc_r     [N];
  logic [LW-1:0] lc_nx_s  [N];
  logic [N-1:0]  state_r, state_nx_s;
  logic [N-1:0]  toggle_r, toggle_nx_s;
  logic [N-1:0]  flip_s;
  logic [N-1:0]  pp_r, pl_r, pr_r;
  logic [N-1:0]  set_pp_s, set_pl_s, set_pr_s;
  logic [N-1:0]  clr_pp_s, clr_pl_s, clr_pr_s;
  logic [N-1:0]  pend_s;
  logic          overflow_r;

  // Event FIFO
  logic [EW-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [PW:0]   count_r;
  logic          push_s, pop_s, can_push_s, found_s;
  logic [IDXW-1:0] sel_idx_s;
  logic [1:0]    sel_kind_s;

  // Debounce, toggle and long-press next-state logic, gated by the poll strobe
  always_comb begin
    cnt_nx_s    = cnt_r;
    lc_nx_s     = lc_r;
    state_nx_s  = state_r;
    toggle_nx_s = toggle_r;
    flip_s      = '0;
    set_pp_s    = '0;
    set_pl_s    = '0;
    set_pr_s    = '0;
    for (int i = 0; i < N; i++) begin
      if (sample_valid_i) begin
        if (sample_i[i] == state_r[i]) begin
          cnt_nx_s[i] = '0;
        end else if (cnt_r[i] + CW'(1) == DEB_LIM) begin
          cnt_nx_s[i]   = '0;
          state_nx_s[i] = ~state_r[i];
          flip_s[i]     = 1'b1;
          if (!state_r[i]) begin
            set_pp_s[i]    = 1'b1;
            toggle_nx_s[i] = ~toggle_r[i];
          end else begin
            set_pr_s[i] = 1'b1;
            lc_nx_s[i]  = '0;
          end
        end else begin
          cnt_nx_s[i] = cnt_r[i] + CW'(1);
        end
        // Long counter runs only while held and not on the releasing edge
        if (state_r[i] && !flip_s[i]) begin
          if (lc_r[i] != LONG_LIM) begin
            lc_nx_s[i] = lc_r[i] + LW'(1);
            if (lc_r[i] + LW'(1) == LONG_LIM) begin
              set_pl_s[i] = 1'b1;
            end else begin
              set_pl_s[i] = 1'b0;
            end
          end else begin
            lc_nx_s[i] = lc_r[i];
          end
        end else begin
          set_pl_s[i] = 1'b0;
        end
      end else begin
        cnt_nx_s[i] = cnt_r[i];
      end
    end
  end

  // Scheduler: pick lowest-index pending event (press, long, release) for the FIFO
  always_comb begin
    pend_s     = pp_r | pl_r | pr_r;
    pop_s      = evt_valid_o && evt_ready_i;
    can_push_s = (count_r != FIFO_FULL) || pop_s;
    found_s    = 1'b0;
    sel_idx_s  = '0;
    sel_kind_s = 2'b00;
    clr_pp_s   = '0;
    clr_pl_s   = '0;
    clr_pr_s   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found_s && pend_s[i]) begin
        found_s   = 1'b1;
        sel_idx_s = IDXW'(i);
        if (pp_r[i]) begin
          sel_kind_s  = KIND_PRESS;
          clr_pp_s[i] = can_push_s;
        end else if (pl_r[i]) begin
          sel_kind_s  = KIND_LONG;
          clr_pl_s[i] = can_push_s;
        end else begin
          sel_kind_s  = KIND_REL;
          clr_pr_s[i] = can_push_s;
        end
      end else begin
        found_s = found_s;
      end
    end
    push_s = found_s && can_push_s;
  end

  // Button state, pending bits and sticky overflow registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) begin
        cnt_r[i] <= '0;
        lc_r[i]  <= '0;
      end
      state_r    <= '0;
      toggle_r   <= '0;
      pp_r       <= '0;
      pl_r       <= '0;
      pr_r       <= '0;
      overflow_r <= 1'b0;
    end else begin
      cnt_r      <= cnt_nx_s;
      lc_r       <= lc_nx_s;
      state_r    <= state_nx_s;
      toggle_r   <= toggle_nx_s;
      // A set landing on a still-pending bit loses one event; set wins over clear
      pp_r       <= (pp_r & ~clr_pp_s) | set_pp_s;
      pl_r       <= (pl_r & ~clr_pl_s) | set_pl_s;
      pr_r       <= (pr_r & ~clr_pr_s) | set_pr_s;
      overflow_r <= overflow_r | (|((pp_r & set_pp_s) | (pl_r & set_pl_s) | (pr_r & set_pr_s)));
    end
  end

  // Event FIFO storage, pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        mem_r[j] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {sel_kind_s, sel_idx_s};
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PW + 1)'(1);
        2'b01:   count_r <= count_r - (PW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign state_o     = state_r;
  assign toggle_o    = toggle_r;
  assign overflow_o  = overflow_r;
  assign evt_valid_o = (count_r != '0);
  assign evt_o       = mem_r[rd_ptr_r];

endmodule

// File: tb/tb_capsense_event_filter.sv
// Scoreboard bench for capsense_event_filter: expected events are queued as
// stimulus is applied and compared against each accepted FIFO head.
module tb_capsense_event_filter;

  localparam int N  = 4;
  localparam int EW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [N-1:0]  sample_i;
  logic          sample_valid_i;
  logic [N-1:0]  state_o;
  logic [N-1:0]  toggle_o;
  logic          evt_valid_o;
  logic          evt_ready_i;
  logic [EW-1:0] evt_o;
  logic          overflow_o;

  int n_pass  = 0;
  int n_total = 0;
  logic [EW-1:0] sb [$];

  capsense_event_filter #(
    .N(4), .DEB_CNT(3), .LONG_POLLS(16), .FIFO_DEPTH(4)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .state_o        (state_o),
    .toggle_o       (toggle_o),
    .evt_valid_o    (evt_valid_o),
    .evt_ready_i    (evt_ready_i),
    .evt_o          (evt_o),
    .overflow_o     (overflow_o)
  );

  // Free-running clock
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic strobe(input logic [N-1:0] s, input int n);
    for (int k = 0; k < n; k++) begin
      sample_i       = s;
      sample_valid_i = 1'b1;
      @(posedge clk_i); #1;
      sample_valid_i = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_i); #1;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || evt_valid_o) && k < 40) begin
      idle(1);
      k++;
    end
    check_eq("drain_sb", sb.size(), 0);
    check_eq("drain_valid", evt_valid_o, 1'b0);
  endtask

  // Pop the scoreboard for every event the consumer accepts at the next edge
  always @(negedge clk_i) begin
    if (rst_ni && evt_valid_o && evt_ready_i) begin
      if (sb.size() == 0) begin
        check_eq("unexp_valid", evt_valid_o, 1'b0);
      end else begin
        check_eq("evt", evt_o, sb.pop_front());
      end
    end
  end

  // Hard time limit
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // Stimulus and direct checks
  initial begin
    rst_ni         = 1'b0;
    sample_valid_i = 1'b1;
    sample_i       = 4'b1111;
    evt_ready_i    = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni         = 1'b1;
    sample_valid_i = 1'b0;
    sample_i       = 4'b0000;
    check_eq("rst_state", state_o, 4'b0000);
    check_eq("rst_toggle", toggle_o, 4'b0000);
    check_eq("rst_valid", evt_valid_o, 1'b0);
    check_eq("rst_ovf", overflow_o, 1'b0);

    // Bounce rejection on button 1
    evt_ready_i = 1'b1;
    sb.push_back(4'b0101);
    strobe(4'b0010, 1); idle(1);
    strobe(4'b0010, 1); idle(1);
    strobe(4'b0000, 1);
    strobe(4'b0010, 1);
    strobe(4'b0010, 1);
    check_eq("bounce_hold", state_o, 4'b0000);
    strobe(4'b0010, 1);
    check_eq("bounce_state", state_o, 4'b0010);
    check_eq("bounce_toggle", toggle_o, 4'b0010);
    check_eq("lat_e0", evt_valid_o, 1'b0);
    idle(1);
    check_eq("lat_e1", evt_valid_o, 1'b1);
    check_eq("lat_e1_evt", evt_o, 4'b0101);
    drain();
    sb.push_back(4'b1001);
    strobe(4'b0000, 3);
    check_eq("rel1_state", state_o, 4'b0000);
    drain();
    check_eq("rel1_toggle", toggle_o, 4'b0010);

    // Simultaneous press of all buttons
    sb.push_back(4'b0100); sb.push_back(4'b0101);
    sb.push_back(4'b0110); sb.push_back(4'b0111);
    strobe(4'b1111, 3);
    check_eq("simul_state", state_o, 4'b1111);
    check_eq("simul_toggle", toggle_o, 4'b1101);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      check_eq("simul_valid", evt_valid_o, 1'b1);
    end
    idle(1);
    check_eq("simul_done", evt_valid_o, 1'b0);
    check_eq("simul_sb", sb.size(), 0);
    sb.push_back(4'b1000); sb.push_back(4'b1001);
    sb.push_back(4'b1010); sb.push_back(4'b1011);
    strobe(4'b0000, 3);
    drain();

    // Long press on button 2, one long event per hold
    sb.push_back(4'b0110); sb.push_back(4'b1110); sb.push_back(4'b1010);
    strobe(4'b0100, 19);
    check_eq("long_state", state_o, 4'b0100);
    check_eq("long_toggle", toggle_o, 4'b1001);
    strobe(4'b0100, 40);
    strobe(4'b0000, 3);
    drain();
    check_eq("long_rel_state", state_o, 4'b0000);

    // Backpressure and overflow
    evt_ready_i = 1'b0;
    sb.push_back(4'b0100); sb.push_back(4'b1000);
    sb.push_back(4'b0100); sb.push_back(4'b1000);
    sb.push_back(4'b0100); sb.push_back(4'b1000);
    sb.push_back(4'b0111); sb.push_back(4'b1011);
    strobe(4'b0001, 3); strobe(4'b0000, 3);
    strobe(4'b0001, 3); strobe(4'b0000, 3);
    check_eq("bp_valid", evt_valid_o, 1'b1);
    check_eq("bp_head", evt_o, 4'b0100);
    strobe(4'b1001, 3);
    strobe(4'b0000, 3);
    strobe(4'b0001, 2);
    check_eq("ovf_before", overflow_o, 1'b0);
    check_eq("bp_head_stable", evt_o, 4'b0100);
    strobe(4'b0001, 1);
    check_eq("ovf_set", overflow_o, 1'b1);
    check_eq("bp_toggle", toggle_o, 4'b0001);
    evt_ready_i = 1'b1;
    drain();
    check_eq("ovf_sticky", overflow_o, 1'b1);

    // Reset with events queued
    evt_ready_i = 1'b0;
    strobe(4'b0000, 3);
    strobe(4'b1000, 3);
    strobe(4'b0000, 3);
    idle(2);
    check_eq("rq_valid", evt_valid_o, 1'b1);
    check_eq("rq_head", evt_o, 4'b1000);
    rst_ni         = 1'b0;
    sample_valid_i = 1'b1;
    sample_i       = 4'b1111;
    @(posedge clk_i); #1;
    rst_ni         = 1'b1;
    sample_valid_i = 1'b0;
    sample_i       = 4'b0000;
    check_eq("rq_valid_rst", evt_valid_o, 1'b0);
    check_eq("rq_state_rst", state_o, 4'b0000);
    check_eq("rq_toggle_rst", toggle_o, 4'b0000);
    check_eq("rq_ovf_rst", overflow_o, 1'b0);
    evt_ready_i = 1'b1;
    strobe(4'b0000, 3);
    idle(3);
    check_eq("rq_quiet", evt_valid_o, 1'b0);
    check_eq("rq_sb", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
